// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one EX-stage ALU between two valid/ready requesters.
// Operands are latched on grant, held through multi-cycle multiplies, and results return as a one-cycle pulse.
module alu_arbiter #(
  parameter int unsigned DSIZE   = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DSIZE-1:0] req0_a,
  input  logic [DSIZE-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DSIZE-1:0] req1_a,
  input  logic [DSIZE-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  output logic [DSIZE-1:0] rsp0_data,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  output logic [DSIZE-1:0] rsp1_data,
  output logic             rsp1_zero,
  output logic [DSIZE-1:0] alu_a,
  output logic [DSIZE-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [DSIZE-1:0] alu_out,
  input  logic             alu_zero
);

  // `MUL encoding of the shared ALU opcode set
  localparam logic [2:0]  OP_MUL = 3'b101;
  localparam int unsigned CW     = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             owner_q, owner_d;
  logic [DSIZE-1:0] a_q, a_d;
  logic [DSIZE-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic [DSIZE-1:0] rsp0_data_q, rsp0_data_d;
  logic             rsp0_zero_q, rsp0_zero_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [DSIZE-1:0] rsp1_data_q, rsp1_data_d;
  logic             rsp1_zero_q, rsp1_zero_d;

  logic             grant0_c, grant1_c;
  logic [2:0]       op_sel_c;

  // Round-robin grant: a lone requester wins, a tie goes to the pointer port
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && (!req1_valid || !ptr_q)) begin
        grant0_c = 1'b1;
      end else if (req1_valid) begin
        grant1_c = 1'b1;
      end
    end
  end

  assign req0_ready = grant0_c & rst_n;
  assign req1_ready = grant1_c & rst_n;
  assign op_sel_c   = grant1_c ? req1_op : req0_op;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    rsp0_valid_d = 1'b0;
    rsp0_data_d  = rsp0_data_q;
    rsp0_zero_d  = rsp0_zero_q;
    rsp1_valid_d = 1'b0;
    rsp1_data_d  = rsp1_data_q;
    rsp1_zero_d  = rsp1_zero_q;
    case (state_q)
      IDLE: begin
        if (grant0_c || grant1_c) begin
          owner_d = grant1_c;
          ptr_d   = ~grant1_c;
          a_d     = grant1_c ? req1_a : req0_a;
          b_d     = grant1_c ? req1_b : req0_b;
          op_d    = op_sel_c;
          cnt_d   = (op_sel_c == OP_MUL) ? CW'(MUL_LAT - 1) : '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (owner_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = alu_out;
            rsp1_zero_d  = alu_zero;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = alu_out;
            rsp0_zero_d  = alu_zero;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      cnt_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp0_zero_q  <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      rsp1_zero_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp0_zero_q  <= rsp0_zero_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp1_zero_q  <= rsp1_zero_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp0_zero  = rsp0_zero_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_data  = rsp1_data_q;
  assign rsp1_zero  = rsp1_zero_q;

endmodule
